addertree_arbiter: RTL

Round-robin arbiter and pipeline sequencer that shares one `sum200to1` adder tree between `NREQ` requesters. Each requester offers a vector of 200 `N`-bit terms with a valid/ready handshake. The arbiter grants one requester per cycle, registers the selected terms, and sums them with the shared tree. It returns the registered sum tagged with the requester index. It sits between the modular-square partial-product column generators and the reduction logic, so several column sources use one tree instead of one tree each.

---
 rtl/addertree_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/addertree_arbiter.sv
// addertree_arbiter: round-robin arbiter that shares one 200-term adder tree
// between NREQ requesters, followed by a two-stage pipeline (terms, sum).
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_valid       per-requester offer of 200 N-bit terms
//   o_req_ready       one-hot (or zero) accept, combinational from state and inputs
//   i_req_terms       [NREQ][200] terms, held stable by requester until accepted
//   o_out_valid       result register holds a valid sum
//   i_out_ready       downstream accepts the result
//   o_out_sum         sum of the granted requester's 200 terms (N+8 bits)
//   o_out_id          index of the requester that produced o_out_sum

// Combinational sum of 200 N-bit terms; N+8 bits cannot overflow (200 < 256).
module sum200to1 #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   i_terms [200],
    output logic [N+7:0]   o_sum
);
    logic [N+7:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < 200; i++) begin
            w_acc = w_acc + (N+8)'(i_terms[i]);
        end
        o_sum = w_acc;
    end
endmodule

module addertree_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [N-1:0]      i_req_terms [NREQ][200],
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [N+7:0]      o_out_sum,
    output logic [IDW-1:0]    o_out_id
);
    // S1: granted terms and id
    logic [N-1:0]   r_s1_terms [200];
    logic [IDW-1:0] r_s1_id;
    logic           r_s1_valid;
    // S2: result
    logic [N+7:0]   r_out_sum;
    logic [IDW-1:0] r_out_id;
    logic           r_out_valid;
    // Most recently granted requester; search starts one past it
    logic [IDW-1:0] r_last;

    logic           w_s2_load;
    logic           w_s1_free;
    logic           w_grant_any;
    logic [IDW-1:0] w_grant_id;
    logic [N+7:0]   w_tree_sum;

    assign w_s2_load = r_s1_valid & (~r_out_valid | i_out_ready);
    assign w_s1_free = ~r_s1_valid | w_s2_load;

    // Rotating-priority search from r_last+1 .. r_last+NREQ, only when S1 can accept
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        if (w_s1_free) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                if (!w_grant_any && i_req_valid[IDW'((32'(r_last) + k) % NREQ)]) begin
                    w_grant_any = 1'b1;
                    w_grant_id  = IDW'((32'(r_last) + k) % NREQ);
                end
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (w_grant_any) begin
            o_req_ready[w_grant_id] = 1'b1;
        end
    end

    sum200to1 #(.N(N)) u_tree (
        .i_terms (r_s1_terms),
        .o_sum   (w_tree_sum)
    );

    // Term payload carries no reset; it is only meaningful under r_s1_valid
    always_ff @(posedge i_clk) begin
        if (w_grant_any) begin
            r_s1_terms <= i_req_terms[w_grant_id];
        end
    end

    // Pipeline control and arbitration state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_id    <= '0;
            r_last      <= IDW'(NREQ - 1);
        end else begin
            if (w_s1_free) begin
                r_s1_valid <= w_grant_any;
                if (w_grant_any) begin
                    r_s1_id <= w_grant_id;
                    r_last  <= w_grant_id;
                end
            end
            if (w_s2_load) begin
                r_out_sum   <= w_tree_sum;
                r_out_id    <= r_s1_id;
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_id    = r_out_id;
endmodule
